// File: rtl/sample_rle_pkg.sv
// sample_rle_pkg
//   Shared constants, FSM state type and FIFO word builders for the
//   sample_rle capture front end.
//   Contents:
//     TAG_BIT, SAMPLE_W, RUN_W, WCOUNT_W, WORD_W  - word/field widths
//     STAT_*                                      - status-word field offsets
//     state_t                                     - encoder FSM states
//     data_word()/run_word()                      - FIFO word formatting
package sample_rle_pkg;

    localparam int unsigned TAG_BIT  = 15;
    localparam int unsigned SAMPLE_W = 15;
    localparam int unsigned RUN_W    = 15;
    localparam int unsigned WCOUNT_W = 24;
    localparam int unsigned WORD_W   = TAG_BIT + 1;
    localparam int unsigned STAT_W   = 32;

    // Status word: {overflow, running, 6'b0, wcount[23:0]}
    localparam int unsigned STAT_OVF_BIT    = 31;
    localparam int unsigned STAT_RUN_BIT    = 30;
    localparam int unsigned STAT_WCOUNT_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_CAPTURE,
        ST_PEND_DATA,
        ST_FLUSH
    } state_t;

    // Data word: tag clear, raw sample below it.
    function automatic logic [WORD_W-1:0] data_word(input logic [SAMPLE_W-1:0] sample);
        logic [WORD_W-1:0] w;
        w                 = '0;
        w[SAMPLE_W-1:0]   = sample;
        return w;
    endfunction

    // Run word: tag set, repeat count of the previous data word below it.
    function automatic logic [WORD_W-1:0] run_word(input logic [RUN_W-1:0] n);
        logic [WORD_W-1:0] w;
        w              = '0;
        w[TAG_BIT]     = 1'b1;
        w[RUN_W-1:0]   = n;
        return w;
    endfunction

endpackage

// File: rtl/sample_rle.sv
// sample_rle
//   Capture-side front end of the sample path. Registers 15-bit logic
//   analyser samples and writes 16-bit words into the SDRAM write FIFO.
//   With SAMPLE_RLE_EN defined, repeated samples are run-length encoded
//   (data word {0,sample}, run word {1,n}); with it undefined, every
//   accepted sample is written as a data word.
//   Build option: `define SAMPLE_RLE_EN to enable run-length encoding.
//
//   Parameters:
//     RUN_MAX   longest run carried by one run word (1..32767)
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     s_valid, s_data   sample strobe (never on consecutive cycles) / value
//     f_we, f_data      FIFO write strobe / word (registered)
//     f_full            FIFO full; a word due while full is dropped
//     avalid, awe       register access strobe / write qualifier
//     aaddr             register select (address bit 2); 0 = control
//     adata             write data; bit 0 is the capture enable
//     bvalid            access acknowledge, avalid delayed one cycle
//     bdata             status {overflow, running, 6'b0, wcount[23:0]}
module sample_rle
    import sample_rle_pkg::*;
#(
    parameter int unsigned RUN_MAX = 32767
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                f_we,
    output logic [WORD_W-1:0]   f_data,
    input  logic                f_full,
    input  logic                avalid,
    input  logic                awe,
    input  logic                aaddr,
    input  logic [31:0]         adata,
    output logic                bvalid,
    output logic [STAT_W-1:0]   bdata
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_f_we;
    logic [WORD_W-1:0]     r_f_data;
    logic [WCOUNT_W-1:0]   r_wcount;
    logic                  r_overflow;
    logic                  r_bvalid;
    logic [STAT_W-1:0]     r_bdata;

    logic                  w_wr_ctl;
    logic                  w_en_req;
    logic                  w_dis_req;
    logic                  w_emit;
    logic                  w_we;
    logic                  w_ovf_set;
    logic                  w_clear;
    logic [WORD_W-1:0]     w_word;
    logic [STAT_W-1:0]     w_status;
    logic                  w_unused;

    assign w_wr_ctl  = avalid && awe && (aaddr == 1'b0);
    assign w_en_req  = w_wr_ctl && adata[0];
    assign w_dis_req = w_wr_ctl && !adata[0];

    // A word is only written when the FIFO can take it.
    assign w_we = w_emit && !f_full;

`ifdef SAMPLE_RLE_EN
    localparam logic [RUN_W-1:0] LP_RUN_MAX = RUN_W'(RUN_MAX);

    logic [SAMPLE_W-1:0]   r_last;
    logic [SAMPLE_W-1:0]   w_last_nxt;
    logic [RUN_W-1:0]      r_run;
    logic [RUN_W-1:0]      w_run_nxt;
    logic [RUN_W-1:0]      w_run_inc;
    logic                  r_stop_pend;
    logic                  w_stop_pend_nxt;
    logic                  w_dis_eff;

    assign w_run_inc = r_run + RUN_W'(1);
    assign w_unused  = ^adata[31:1];

    // Two passes: the sample (or pending word) is handled first, then a
    // control write is applied to whatever state that produced. A disable
    // landing on PEND_DATA is parked in r_stop_pend and replayed once the
    // queued data word is out.
    always_comb begin
        w_state_nxt     = r_state;
        w_emit          = 1'b0;
        w_word          = '0;
        w_ovf_set       = 1'b0;
        w_clear         = 1'b0;
        w_last_nxt      = r_last;
        w_run_nxt       = r_run;
        w_stop_pend_nxt = 1'b0;
        w_dis_eff       = w_dis_req || ((r_state == ST_PEND_DATA) && r_stop_pend);

        case (r_state)
            ST_WAIT_FIRST: begin
                if (s_valid) begin
                    w_emit      = 1'b1;
                    w_word      = data_word(s_data);
                    w_last_nxt  = s_data;
                    w_run_nxt   = '0;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (s_valid) begin
                    if (s_data == r_last) begin
                        if (w_run_inc == LP_RUN_MAX) begin
                            w_emit    = 1'b1;
                            w_word    = run_word(LP_RUN_MAX);
                            w_run_nxt = '0;
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end else if (r_run == '0) begin
                        w_emit     = 1'b1;
                        w_word     = data_word(s_data);
                        w_last_nxt = s_data;
                    end else begin
                        w_emit      = 1'b1;
                        w_word      = run_word(r_run);
                        w_run_nxt   = '0;
                        w_last_nxt  = s_data;
                        w_state_nxt = ST_PEND_DATA;
                    end
                end
            end
            ST_PEND_DATA: begin
                w_emit      = 1'b1;
                w_word      = data_word(r_last);
                w_state_nxt = ST_CAPTURE;
            end
            ST_FLUSH: begin
                w_emit      = 1'b1;
                w_word      = run_word(r_run);
                w_run_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: ;
        endcase

        // Dropped word: the stream is no longer decodable, so stop.
        if (w_emit && f_full) begin
            w_ovf_set   = 1'b1;
            w_run_nxt   = '0;
            w_state_nxt = ST_IDLE;
        end

        case (w_state_nxt)
            ST_IDLE: begin
                if (w_en_req) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_WAIT_FIRST;
                end
            end
            ST_WAIT_FIRST: begin
                if (w_dis_eff) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (w_dis_eff) begin
                    w_state_nxt = (w_run_nxt != '0) ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_PEND_DATA: begin
                if (w_dis_eff) begin
                    w_stop_pend_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= '0;
            r_run       <= '0;
            r_stop_pend <= 1'b0;
        end else begin
            r_last      <= w_last_nxt;
            r_run       <= w_run_nxt;
            r_stop_pend <= w_stop_pend_nxt;
        end
    end
`else
    // RUN_MAX has no effect without run-length encoding.
    assign w_unused = ^{adata[31:1], (RUN_MAX != 0)};

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_word      = '0;
        w_ovf_set   = 1'b0;
        w_clear     = 1'b0;

        case (r_state)
            ST_WAIT_FIRST, ST_CAPTURE: begin
                if (s_valid) begin
                    w_emit      = 1'b1;
                    w_word      = data_word(s_data);
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_IDLE: ;
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_emit && f_full) begin
            w_ovf_set   = 1'b1;
            w_state_nxt = ST_IDLE;
        end

        case (w_state_nxt)
            ST_IDLE: begin
                if (w_en_req) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_WAIT_FIRST;
                end
            end
            ST_WAIT_FIRST, ST_CAPTURE: begin
                if (w_dis_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: ;
        endcase
    end
`endif

    always_comb begin
        w_status                                  = '0;
        w_status[STAT_OVF_BIT]                    = r_overflow;
        w_status[STAT_RUN_BIT]                    = (r_state != ST_IDLE);
        w_status[STAT_WCOUNT_LSB +: WCOUNT_W]     = r_wcount;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_f_we     <= 1'b0;
            r_f_data   <= '0;
            r_wcount   <= '0;
            r_overflow <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bdata    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_f_we   <= w_we;
            if (w_we) begin
                r_f_data <= w_word;
            end
            // Enable clears the counters even if a word lands the same cycle.
            if (w_clear) begin
                r_wcount   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_we) begin
                    r_wcount <= r_wcount + WCOUNT_W'(1);
                end
                if (w_ovf_set) begin
                    r_overflow <= 1'b1;
                end
            end
            r_bvalid <= avalid;
            r_bdata  <= w_status;
        end
    end

    assign f_we   = r_f_we;
    assign f_data = r_f_data;
    assign bvalid = r_bvalid;
    assign bdata  = r_bdata;

endmodule

// File: tb/tb_sample_rle.sv
module tb_sample_rle;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        s_valid = 1'b0;
    logic [14:0] s_data  = '0;
    logic        f_full  = 1'b0;
    logic        avalid  = 1'b0;
    logic        awe     = 1'b0;
    logic        aaddr   = 1'b0;
    logic [31:0] adata   = '0;
    logic        f_we;
    logic [15:0] f_data;
    logic        bvalid;
    logic [31:0] bdata;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    sample_rle #(.RUN_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .f_we    (f_we),
        .f_data  (f_data),
        .f_full  (f_full),
        .avalid  (avalid),
        .awe     (awe),
        .aaddr   (aaddr),
        .adata   (adata),
        .bvalid  (bvalid),
        .bdata   (bdata)
    );

    always #5 clk = ~clk;

    // Collect every FIFO write, sampled mid-cycle.
    always @(negedge clk) begin
        if (f_we === 1'b1) got_q.push_back(f_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [14:0] v, input bit with_disable = 1'b0);
        s_valid = 1'b1;
        s_data  = v;
        if (with_disable) begin
            avalid = 1'b1;
            awe    = 1'b1;
            aaddr  = 1'b0;
            adata  = 32'h0;
        end
        tick();
        s_valid = 1'b0;
        avalid  = 1'b0;
        awe     = 1'b0;
        tick();
    endtask

    task automatic reg_write(input logic a, input logic [31:0] d);
        avalid = 1'b1;
        awe    = 1'b1;
        aaddr  = a;
        adata  = d;
        tick();
        avalid = 1'b0;
        awe    = 1'b0;
        aaddr  = 1'b0;
        adata  = '0;
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp);
        tick(3);
        check(tag, bdata, exp);
    endtask

    task automatic check_words(input string tag);
        check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i),
                  (i < got_q.size()) ? {16'h0, got_q[i]} : 32'hxxxxxxxx,
                  {16'h0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        check("rst_f_we",   {31'h0, f_we},   32'h0);
        check("rst_f_data", {16'h0, f_data}, 32'h0);
        check("rst_bvalid", {31'h0, bvalid}, 32'h0);
        check("rst_bdata",  bdata,           32'h0);
        rst_n = 1'b1;
        tick(2);

        // Samples in IDLE are ignored
        send_sample(15'h1234);
        check_status("idle_status", 32'h0000_0000);
        check_words("idle");

        // A: 1,1,1,2 plus ignored writes (reserved addr, enable while running)
        reg_write(1'b0, 32'h1);
        check_status("A_arm", 32'h4000_0000);
        send_sample(15'h0001);
        send_sample(15'h0001);
        send_sample(15'h0001);
        reg_write(1'b1, 32'h0);
        reg_write(1'b0, 32'h1);
        send_sample(15'h0002);
`ifdef SAMPLE_RLE_EN
        check_status("A_run", 32'h4000_0003);
        reg_write(1'b0, 32'h0);
        check_status("A_stop", 32'h0000_0003);
        exp_q = '{16'h0001, 16'h8002, 16'h0002};
`else
        check_status("A_run", 32'h4000_0004);
        reg_write(1'b0, 32'h0);
        check_status("A_stop", 32'h0000_0004);
        exp_q = '{16'h0001, 16'h0001, 16'h0001, 16'h0002};
`endif
        check_words("A");

        // B: six equal samples with RUN_MAX=4, then disable
        reg_write(1'b0, 32'h1);
        for (int i = 0; i < 6; i++) send_sample(15'h0005);
        reg_write(1'b0, 32'h0);
`ifdef SAMPLE_RLE_EN
        check_status("B_stop", 32'h0000_0003);
        exp_q = '{16'h0005, 16'h8004, 16'h8001};
`else
        check_status("B_stop", 32'h0000_0006);
        exp_q = '{16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005};
`endif
        check_words("B");

        // C: one sample, disable with run=0; acknowledge and status timing
        reg_write(1'b0, 32'h1);
        send_sample(15'h0003);
        reg_write(1'b0, 32'h0);
        check("C_bvalid_hi", {31'h0, bvalid}, 32'h1);
        check("C_bdata_old", bdata, 32'h4000_0001);
        tick();
        check("C_bvalid_lo", {31'h0, bvalid}, 32'h0);
        check("C_bdata_new", bdata, 32'h0000_0001);
        tick(2);
        exp_q = '{16'h0003};
        check_words("C");

        // D: FIFO full on the first data word, then re-enable clears overflow
        reg_write(1'b0, 32'h1);
        f_full = 1'b1;
        send_sample(15'h0009);
        f_full = 1'b0;
        check_status("D_ovf", 32'h8000_0000);
        send_sample(15'h0009);
        check_status("D_ovf_idle", 32'h8000_0000);
        check_words("D");
        reg_write(1'b0, 32'h1);
        check_status("D_rearm", 32'h4000_0000);
        reg_write(1'b0, 32'h0);
        check_status("D_off", 32'h0000_0000);

        // E: sample and disable in the same cycle
        reg_write(1'b0, 32'h1);
        send_sample(15'h0004);
        send_sample(15'h0004);
        send_sample(15'h0006, 1'b1);
        check_status("E_stop", 32'h0000_0003);
`ifdef SAMPLE_RLE_EN
        exp_q = '{16'h0004, 16'h8001, 16'h0006};
`else
        exp_q = '{16'h0004, 16'h0004, 16'h0006};
`endif
        check_words("E");

        // F: reset mid-run aborts without a flush
        reg_write(1'b0, 32'h1);
        for (int i = 0; i < 4; i++) send_sample(15'h0008);
        avalid = 1'b1;
        #3;
        rst_n = 1'b0;
        avalid = 1'b0;
        tick();
        check("F_rst_f_we",   {31'h0, f_we},   32'h0);
        check("F_rst_f_data", {16'h0, f_data}, 32'h0);
        check("F_rst_bvalid", {31'h0, bvalid}, 32'h0);
        check("F_rst_bdata",  bdata,           32'h0);
        rst_n = 1'b1;
        tick(6);
        check("F_after", bdata, 32'h0000_0000);
`ifdef SAMPLE_RLE_EN
        exp_q = '{16'h0008};
`else
        exp_q = '{16'h0008, 16'h0008, 16'h0008, 16'h0008};
`endif
        check_words("F");
        send_sample(15'h0008);
        check_status("F_idle", 32'h0000_0000);
        check_words("F_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
